// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and any load/store unit.
// Holds the RISC-V load/store funct3 width codes, the responder state enum
// and a helper that classifies funct3/we combinations as illegal.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Unsigned widths exist only for loads; codes 011/110/111 are never legal.
  function automatic logic f3_illegal(input logic [2:0] funct3, input logic we);
    logic v;
    case (funct3)
      F3_B, F3_H, F3_W: v = 1'b0;
      F3_BU, F3_HU:     v = we;
      default:          v = 1'b1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment for 32-bit little-endian memory.
// Ports:
//   i_addr_lo   byte offset within the word (addr[1:0])
//   i_funct3    RISC-V load/store width code
//   i_wdata     raw store data (low bits used for B/H)
//   i_rword     word read from the array
//   o_byte_en   per-lane write enables for a store
//   o_wword     store data replicated onto the selected lanes
//   o_rdata_ext load result, sign/zero-extended
//   o_misalign  access not naturally aligned for its width
module lsu_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata_ext,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  // Lane enables, replicated store data, extended load data and alignment.
  always_comb begin
    o_byte_en   = 4'b0000;
    o_wword     = 32'h0000_0000;
    o_rdata_ext = 32'h0000_0000;
    o_misalign  = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_byte_en   = 4'b0001 << i_addr_lo;
        o_wword     = {4{i_wdata[7:0]}};
        o_rdata_ext = {{24{w_byte[7]}}, w_byte};
      end
      F3_BU: begin
        o_rdata_ext = {24'h00_0000, w_byte};
      end
      F3_H: begin
        o_byte_en   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword     = {2{i_wdata[15:0]}};
        o_rdata_ext = {{16{w_half[15]}}, w_half};
        o_misalign  = i_addr_lo[0];
      end
      F3_HU: begin
        o_rdata_ext = {16'h0000, w_half};
        o_misalign  = i_addr_lo[0];
      end
      F3_W: begin
        o_byte_en   = 4'b1111;
        o_wword     = i_wdata;
        o_rdata_ext = i_rword;
        o_misalign  = (i_addr_lo != 2'b00);
      end
      default: begin
        o_byte_en   = 4'b0000;
        o_wword     = 32'h0000_0000;
        o_rdata_ext = 32'h0000_0000;
        o_misalign  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port. Accepts one request
// per valid/ready handshake and presents the response LATENCY edges later,
// holding it until the initiator accepts it.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_we/addr/funct3/wdata request payload (store flag, byte address, width, data)
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/rsp_err        load data (0 for stores/errors) and error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [31:0]   ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  dmem_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [2:0]    r_funct3;
  logic [31:0]   r_wdata;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [3:0]    w_byte_en;
  logic [31:0]   w_wword;
  logic [31:0]   w_rdata_ext;
  logic          w_misalign;
  logic          w_err;
  logic          w_access;

  assign w_idx    = r_addr[AW+1:2];
  assign w_rword  = r_mem[w_idx];
  // Error priority order does not change the outcome: any error gives err=1, rdata=0.
  assign w_err    = f3_illegal(r_funct3, r_we) | w_misalign | (r_addr >= ADDR_LIMIT);
  assign w_access = (r_state == BUSY) && (r_cnt == '0);

  lsu_align u_align (
    .i_addr_lo   (r_addr[1:0]),
    .i_funct3    (r_funct3),
    .i_wdata     (r_wdata),
    .i_rword     (w_rword),
    .o_byte_en   (w_byte_en),
    .o_wword     (w_wword),
    .o_rdata_ext (w_rdata_ext),
    .o_misalign  (w_misalign)
  );

  // Byte-lane array write on the access edge; a reset on that edge cancels it.
  always_ff @(posedge clk) begin
    if (rst && w_access && r_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byte_en[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

  // Request/response controller with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= 32'h0000_0000;
      r_funct3  <= 3'b000;
      r_wdata   <= 32'h0000_0000;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_addr    <= req_addr;
            r_funct3  <= req_funct3;
            r_wdata   <= req_wdata;
            r_cnt     <= CNT_INIT;
            req_ready <= 1'b0;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            rsp_err   <= w_err;
            rsp_rdata <= (w_err || r_we) ? 32'h0000_0000 : w_rdata_ext;
            rsp_valid <= 1'b1;
            r_state   <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table from the reference
// scenarios, backpressure, mid-operation reset and randomized traffic checked
// against a byte-addressed behavioural memory model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [0:DEPTH*4-1];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RISC-V load/store semantics on a flat byte array.
  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [2:0] f3, input logic [31:0] wd,
                                       output logic err, output logic [31:0] rd);
    int size;
    logic illegal;
    logic [31:0] val;
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      default: size = 4;
    endcase
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    err = illegal || ((addr % size) != 0) || (addr >= LIMIT);
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[addr + i] = wd[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < size; i++) val = val | (32'(ref_mem[addr + i]) << (8 * i));
        if (!f3[2] && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
        if (!f3[2] && size == 2 && val[15]) val = val | 32'hFFFF_0000;
        rd = val;
      end
    end
  endfunction

  // Issue one request and collect its response; hold = cycles of rsp_ready=0.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic stable_ok, output logic done_ok);
    int w;
    rd = 32'h0; er = 1'b0; stable_ok = 1'b0; done_ok = 1'b0; lat = -1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) return;
    req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 20) begin @(posedge clk); #1; w++; end
    if (!rsp_valid) begin rsp_ready = 1'b1; return; end
    lat = w;
    rd = rsp_rdata; er = rsp_err;
    stable_ok = !req_ready;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || req_ready) stable_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    done_ok = !rsp_valid && req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset: req_ready=%b rsp_valid=%b rdata=%h err=%b required 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic        t_we [12]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_ad [12]  = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h13, 32'h10, 32'h11, 32'h12,
                                32'h10, LIMIT, 32'h12, 32'h12};
    logic [2:0]  t_f3 [12]  = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b010,
                                3'b010, 3'b010, 3'b101, 3'b011};
    logic [31:0] t_wd [12]  = '{32'hDEADBEEF, 32'h0, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h11111111, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] t_rd [12]  = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hFFFFFF80, 32'h00000080,
                                32'h80ADBEEF, 32'h0, 32'h0, 32'h80ADBEEF, 32'h0, 32'h000080AD, 32'h0};
    logic        t_er [12]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] rd;
    logic er, st, dn, m_er;
    logic [31:0] m_rd;
    int lat;
    for (int i = 0; i < 12; i++) begin
      model_access(t_we[i], t_ad[i], t_f3[i], t_wd[i], m_er, m_rd);
      do_req(t_we[i], t_ad[i], t_f3[i], t_wd[i], 0, rd, er, lat, st, dn);
      checks++;
      if (rd !== t_rd[i] || er !== t_er[i]) begin
        errors++;
        $display("FAIL directed[%0d] data: got rdata=%h err=%b required rdata=%h err=%b",
                 i, rd, er, t_rd[i], t_er[i]);
      end
      checks++;
      if (lat !== LAT || !st || !dn) begin
        errors++;
        $display("FAIL directed[%0d] handshake: latency=%0d stable=%b done=%b required %0d 1 1",
                 i, lat, st, dn, LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, rd2;
    logic er, er2, st, dn, ok, m_er;
    logic [31:0] m_rd;
    int w, lat;
    model_access(1'b0, 32'h10, 3'b010, 32'h0, m_er, m_rd);
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = 32'h0;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 20) begin @(posedge clk); #1; w++; end
    rd = rsp_rdata; er = rsp_err;
    checks++;
    if (!rsp_valid || rd !== m_rd || er !== m_er) begin
      errors++;
      $display("FAIL bp_response: valid=%b rdata=%h err=%b required 1 %h %b", rsp_valid, rd, er, m_rd, m_er);
    end
    // A competing store is offered while the response is stalled.
    req_we = 1'b1; req_funct3 = 3'b010; req_wdata = 32'h0BAD_0BAD; req_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || req_ready) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_stall: valid=%b rdata=%h req_ready=%b required 1 %h 0", rsp_valid, rsp_rdata, req_ready, rd);
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, 0, rd2, er2, lat, st, dn);
    checks++;
    if (rd2 !== m_rd || er2 !== 1'b0) begin
      errors++;
      $display("FAIL bp_ignored_store: rdata=%h err=%b required %h 0", rd2, er2, m_rd);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd;
    logic er, st, dn, ok, m_er;
    logic [31:0] m_rd;
    int lat;
    model_access(1'b1, 32'h20, 3'b010, 32'hCAFEF00D, m_er, m_rd);
    do_req(1'b1, 32'h20, 3'b010, 32'hCAFEF00D, 0, rd, er, lat, st, dn);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'h0000_1234;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ok = (req_ready === 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midop_no_response: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end
    do_req(1'b0, 32'h20, 3'b010, 32'h0, 0, rd, er, lat, st, dn);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++;
      $display("FAIL midop_store_lost: rdata=%h err=%b required cafef00d 0", rd, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd, m_rd;
    logic er, st, dn, we, m_er;
    logic [2:0] f3;
    int lat, hold, sel;
    for (int a = 0; a < 64; a += 4) begin
      wd = $urandom;
      model_access(1'b1, 32'(a), 3'b010, wd, m_er, m_rd);
      do_req(1'b1, 32'(a), 3'b010, wd, 0, rd, er, lat, st, dn);
    end
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       addr = 32'($urandom_range(0, 63));
      else if (sel == 8) addr = LIMIT + 32'($urandom_range(0, 15));
      else               addr = $urandom;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      hold = $urandom_range(0, 3);
      model_access(we, addr, f3, wd, m_er, m_rd);
      do_req(we, addr, f3, wd, hold, rd, er, lat, st, dn);
      checks++;
      if (rd !== m_rd || er !== m_er) begin
        errors++;
        $display("FAIL random[%0d] we=%b f3=%0d addr=%h: rdata=%h err=%b required %h %b",
                 n, we, f3, addr, rd, er, m_rd, m_er);
      end
      checks++;
      if (lat !== LAT || !st || !dn) begin
        errors++;
        $display("FAIL random[%0d] handshake: latency=%0d stable=%b done=%b required %0d 1 1",
                 n, lat, st, dn, LAT);
      end
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_funct3 = 3'b000; req_wdata = 32'h0; rsp_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
